// File: rtl/instr_mem_arbiter.sv
// Arbitrates the single-port instruction RAM between the fetch unit (reads) and the
// program loader (writes), sequencing 3-cycle reads and 2-cycle writes with round-robin.
module instr_mem_arbiter #(
  parameter int ADDRESS_BUS_WIDTH = 10,
  parameter int INSTRUCTION_WIDTH = 19
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fetch_valid,
  input  logic [ADDRESS_BUS_WIDTH-1:0] fetch_addr,
  output logic                         fetch_ready,
  output logic                         fetch_rvalid,
  output logic [INSTRUCTION_WIDTH-1:0] fetch_rdata,
  input  logic                         load_valid,
  input  logic [ADDRESS_BUS_WIDTH-1:0] load_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] load_wdata,
  output logic                         load_ready,
  output logic                         addr_err,
  output logic [ADDRESS_BUS_WIDTH-1:0] load_count,
  output logic [ADDRESS_BUS_WIDTH-1:0] ram_addr,
  output logic                         ram_read,
  output logic                         ram_write,
  output logic [INSTRUCTION_WIDTH-1:0] ram_wdata,
  input  logic [INSTRUCTION_WIDTH-1:0] ram_rdata
);

  localparam int AW = ADDRESS_BUS_WIDTH;
  localparam int IW = INSTRUCTION_WIDTH;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_RESP  = 2'd2,
    WR_ISSUE = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_LOAD  = 1'b1
  } grant_t;

  function automatic logic [AW-1:0] word_align(input logic [AW-1:0] a);
    return {a[AW-1:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [AW-1:0] a);
    return |a[1:0];
  endfunction

  state_t          state_q, state_d;
  grant_t          last_grant_q, last_grant_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic            ram_read_q, ram_read_d;
  logic            ram_write_q, ram_write_d;
  logic [IW-1:0]   ram_wdata_q, ram_wdata_d;
  logic            fetch_rvalid_q, fetch_rvalid_d;
  logic [IW-1:0]   rdata_hold_q, rdata_hold_d;
  logic            addr_err_q, addr_err_d;
  logic [AW-1:0]   load_count_q, load_count_d;

  logic            grant_fetch;
  logic            grant_load;

  // Grant decision: only from IDLE, never while reset is held, one winner at most.
  always_comb begin
    grant_fetch = 1'b0;
    grant_load  = 1'b0;
    if (!reset && state_q == IDLE) begin
      if (fetch_valid && load_valid) begin
        grant_load  = (last_grant_q == GRANT_FETCH);
        grant_fetch = (last_grant_q == GRANT_LOAD);
      end else begin
        grant_fetch = fetch_valid;
        grant_load  = load_valid;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    ram_addr_d     = ram_addr_q;
    ram_wdata_d    = ram_wdata_q;
    rdata_hold_d   = rdata_hold_q;
    load_count_d   = load_count_q;
    ram_read_d     = 1'b0;
    ram_write_d    = 1'b0;
    fetch_rvalid_d = 1'b0;
    addr_err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_fetch) begin
          state_d      = RD_ISSUE;
          last_grant_d = GRANT_FETCH;
          ram_read_d   = 1'b1;
          ram_addr_d   = word_align(fetch_addr);
          addr_err_d   = is_misaligned(fetch_addr);
        end else if (grant_load) begin
          state_d      = WR_ISSUE;
          last_grant_d = GRANT_LOAD;
          ram_write_d  = 1'b1;
          ram_addr_d   = word_align(load_addr);
          ram_wdata_d  = load_wdata;
          addr_err_d   = is_misaligned(load_addr);
        end
      end
      RD_ISSUE: begin
        state_d        = RD_RESP;
        fetch_rvalid_d = 1'b1;
      end
      RD_RESP: begin
        state_d      = IDLE;
        rdata_hold_d = ram_rdata;
      end
      WR_ISSUE: begin
        state_d      = IDLE;
        load_count_d = load_count_q + AW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Single register stage: RAM strobes are launched on the accept edge so they
  // are visible in the cycle after the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      last_grant_q   <= GRANT_FETCH;
      ram_addr_q     <= '0;
      ram_read_q     <= 1'b0;
      ram_write_q    <= 1'b0;
      ram_wdata_q    <= '0;
      fetch_rvalid_q <= 1'b0;
      rdata_hold_q   <= '0;
      addr_err_q     <= 1'b0;
      load_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      ram_addr_q     <= ram_addr_d;
      ram_read_q     <= ram_read_d;
      ram_write_q    <= ram_write_d;
      ram_wdata_q    <= ram_wdata_d;
      fetch_rvalid_q <= fetch_rvalid_d;
      rdata_hold_q   <= rdata_hold_d;
      addr_err_q     <= addr_err_d;
      load_count_q   <= load_count_d;
    end
  end

  assign fetch_ready  = grant_fetch;
  assign load_ready   = grant_load;
  assign fetch_rvalid = fetch_rvalid_q;
  // Response data comes straight from the RAM in RD_RESP and is held afterwards.
  assign fetch_rdata  = fetch_rvalid_q ? ram_rdata : rdata_hold_q;
  assign addr_err     = addr_err_q;
  assign load_count   = load_count_q;
  assign ram_addr     = ram_addr_q;
  assign ram_read     = ram_read_q;
  assign ram_write    = ram_write_q;
  assign ram_wdata    = ram_wdata_q;

  a_ram_excl: assert property (@(posedge clk) !(ram_read_q && ram_write_q));
  a_one_ready: assert property (@(posedge clk) !(grant_fetch && grant_load));

endmodule
